// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared constants, state encodings and types for the register-dump controller.
// The dump walks GPRs first, then the edge-collision registers.
package regfile_dump_ctrl_pkg;

  localparam int unsigned NUM_GPR  = 32;
  localparam int unsigned NUM_ECR  = 6;
  localparam int unsigned DUMP_LEN = NUM_GPR + NUM_ECR;
  localparam int unsigned DATA_W   = 34;
  localparam int unsigned GPR_W    = 32;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned GPR_AW   = 5;
  localparam int unsigned ECR_AW   = 3;
  localparam int unsigned FIFO_W   = IDX_W + DATA_W;
  localparam int unsigned STATE_W  = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_HALT = 3'd1;
  localparam logic [STATE_W-1:0] ST_READ      = 3'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN     = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE      = 3'd4;

  localparam logic [31:0] HALT_INSTR = 32'h0;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } dump_word_t;

  // A zero instruction only means "halted" once the core has left the reset vector.
  function automatic logic is_halt(input logic [31:0] instr, input logic [31:0] pc);
    return (instr == HALT_INSTR) && (pc != 32'h0);
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Valid/ready stream carrying one indexed register word per transfer.
interface regfile_dump_ctrl_if;
  import regfile_dump_ctrl_pkg::*;

  logic              valid;
  logic              ready;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] data;

  modport master (output valid, output idx, output data, input ready);
  modport slave  (input valid, input idx, input data, output ready);

endinterface

// File: rtl/regfile_dump_fifo.sv
// Two-entry synchronous FIFO holding {idx, data} words awaiting the consumer.
// A push and a pop in the same cycle are legal even when full.
module regfile_dump_fifo
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_W
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             wr_en_c;
  logic             rd_en_c;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign rd_en_c = pop_i && !empty_o;
  assign wr_en_c = push_i && (!full_o || rd_en_c);

  always_ff @(posedge clk) begin
    if (rstb) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en_c) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_en_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(wr_en_c) - 2'(rd_en_c);
    end
  end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// End-of-program register dump: waits for halt, reads GPRs then ECRs through
// ports shared with the core (core has priority) and streams indexed words out.
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int unsigned NUM_GPR = regfile_dump_ctrl_pkg::NUM_GPR,
  parameter int unsigned NUM_ECR = regfile_dump_ctrl_pkg::NUM_ECR,
  parameter int unsigned DATA_W  = regfile_dump_ctrl_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 start_i,
  input  logic [31:0]          instr_i,
  input  logic [31:0]          pc_i,
  input  logic                 core_rd_req_i,
  output logic                 rf_rd_en_o,
  output logic [GPR_AW-1:0]    rf_rd_addr_o,
  input  logic [GPR_W-1:0]     rf_rd_data_i,
  output logic                 ec_rd_en_o,
  output logic [ECR_AW-1:0]    ec_rd_addr_o,
  input  logic [DATA_W-1:0]    ec_rd_data_i,
  regfile_dump_ctrl_if.master  dump,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned LAST_IDX = NUM_GPR + NUM_ECR - 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               infl_q, infl_d;
  logic               infl_ec_q, infl_ec_d;
  logic [IDX_W-1:0]   infl_idx_q, infl_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               halt_c;
  logic               is_gpr_c;
  logic               pop_c;
  logic [2:0]         occ_c;
  logic               issue_c;

  dump_word_t         wdata_c;
  dump_word_t         rdata_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic [1:0]         fifo_count;

  assign halt_c   = is_halt(instr_i, pc_i);
  assign is_gpr_c = (idx_q < IDX_W'(NUM_GPR));
  assign pop_c    = dump.valid && dump.ready;

  // Words already queued or in flight, net of the word leaving this cycle.
  assign occ_c   = 3'(fifo_count) + 3'(infl_q) - 3'(pop_c);
  assign issue_c = !rstb && (state_q == ST_READ) && !core_rd_req_i &&
                   (occ_c < 3'd2) && !(fifo_full && !pop_c);

  assign rf_rd_en_o   = issue_c && is_gpr_c;
  assign rf_rd_addr_o = rf_rd_en_o ? idx_q[GPR_AW-1:0] : '0;
  assign ec_rd_en_o   = issue_c && !is_gpr_c;
  assign ec_rd_addr_o = ec_rd_en_o ? ECR_AW'(idx_q - IDX_W'(NUM_GPR)) : '0;

  // Register data returns one cycle after the strobe; capture it with its index.
  assign wdata_c.idx  = infl_idx_q;
  assign wdata_c.data = infl_ec_q ? ec_rd_data_i : DATA_W'(rf_rd_data_i);

  regfile_dump_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .push_i  (infl_q),
    .wdata_i (wdata_c),
    .pop_i   (pop_c),
    .rdata_o (rdata_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign dump.valid = !fifo_empty;
  assign dump.idx   = rdata_c.idx;
  assign dump.data  = rdata_c.data;

  assign busy_o = busy_q;
  assign done_o = done_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    infl_d     = issue_c;
    infl_ec_d  = !is_gpr_c;
    infl_idx_d = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_WAIT_HALT;
      end
      ST_WAIT_HALT: begin
        if (halt_c) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
      end
      ST_READ: begin
        if (issue_c) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_d = ST_DRAIN;
            idx_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        // Finish once the last word is leaving and nothing is left behind it.
        if (!infl_q && ((fifo_count - 2'(pop_c)) == 2'd0)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      infl_q     <= 1'b0;
      infl_ec_q  <= 1'b0;
      infl_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      infl_q     <= infl_d;
      infl_ec_q  <= infl_ec_d;
      infl_idx_q <= infl_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: a register-file responder model feeds
// read data back, expected words are queued per dump and checked on each handshake.
module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        core_rd_req_i;
  logic        rf_rd_en_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_rd_data_i;
  logic        ec_rd_en_o;
  logic [2:0]  ec_rd_addr_o;
  logic [33:0] ec_rd_data_i;
  logic        busy_o;
  logic        done_o;

  regfile_dump_ctrl_if dump_if();

  always #5 clk = ~clk;

  regfile_dump_ctrl dut (
    .clk           (clk),
    .rstb          (rstb),
    .start_i       (start_i),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .core_rd_req_i (core_rd_req_i),
    .rf_rd_en_o    (rf_rd_en_o),
    .rf_rd_addr_o  (rf_rd_addr_o),
    .rf_rd_data_i  (rf_rd_data_i),
    .ec_rd_en_o    (ec_rd_en_o),
    .ec_rd_addr_o  (ec_rd_addr_o),
    .ec_rd_data_i  (ec_rd_data_i),
    .dump          (dump_if),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int words    = 0;
  int last_pop_cyc = -1;
  int last_pop_idx = -1;
  int outst    = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_w;
  logic        hs;

  logic [31:0] gpr [32];
  logic [33:0] ecr [6];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model: data is valid the cycle after the read strobe.
  always @(posedge clk) begin
    rf_rd_data_i <= rf_rd_en_o ? gpr[rf_rd_addr_o] : 32'hDEAD_BEEF;
    ec_rd_data_i <= (ec_rd_en_o && ec_rd_addr_o < 3'd6) ? ecr[ec_rd_addr_o] : 34'h2_DEAD_BEEF;
  end

  // Monitor: core priority, outstanding reads, and scoreboard on each handshake.
  always @(negedge clk) begin
    if (rstb) begin
      outst = 0;
    end else begin
      hs = dump_if.valid && dump_if.ready;
      outst = outst + int'(rf_rd_en_o || ec_rd_en_o) - int'(hs);
      if (rf_rd_en_o || ec_rd_en_o) begin
        check_eq("core_priority", 64'(core_rd_req_i), 64'd0);
        check_eq("single_strobe", 64'(rf_rd_en_o && ec_rd_en_o), 64'd0);
        check_eq("outstanding_le2", 64'(outst <= 2), 64'd1);
      end
      if (hs) begin
        check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check_eq("word_idx", 64'(dump_if.idx), 64'(exp_w[39:34]));
          check_eq("word_data", 64'(dump_if.data), 64'(exp_w[33:0]));
        end
        words++;
        last_pop_cyc = cyc;
        last_pop_idx = int'(dump_if.idx);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < 38; k++) begin
      if (k < 32) exp_q.push_back({6'(k), 34'(k * 3)});
      else        exp_q.push_back({6'(k), 34'h3_0000_0000 + 34'(k - 32)});
    end
  endtask

  // Pulse start, then present the halt condition; h is the cycle halt is sampled.
  task automatic begin_dump(output int h);
    instr_i = 32'h0000_0013;
    pc_i    = 32'h10;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    push_expected();
    instr_i = 32'h0;
    pc_i    = 32'h40;
    h       = cyc;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 400 && done_cnt < target; i++) step(1);
    check_eq(tag, 64'(done_cnt), 64'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rf"}, 64'({rf_rd_en_o, rf_rd_addr_o}), 64'd0);
    check_eq({tag, "_ec"}, 64'({ec_rd_en_o, ec_rd_addr_o}), 64'd0);
    check_eq({tag, "_valid"}, 64'(dump_if.valid), 64'd0);
    check_eq({tag, "_idx"}, 64'(dump_if.idx), 64'd0);
    check_eq({tag, "_data"}, 64'(dump_if.data), 64'd0);
    check_eq({tag, "_busy_done"}, 64'({busy_o, done_o}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int d0;
    int w0;

    for (int k = 0; k < 32; k++) gpr[k] = 32'(k * 3);
    for (int j = 0; j < 6; j++)  ecr[j] = 34'h3_0000_0000 + 34'(j);
    rstb          = 1'b1;
    start_i       = 1'b0;
    instr_i       = 32'h0000_0013;
    pc_i          = 32'h0;
    core_rd_req_i = 1'b0;
    dump_if.ready = 1'b1;

    // Reset state
    step(3);
    check_all_zero("reset");
    rstb = 1'b0;
    step(2);

    // Full dump with exact timing
    d0 = done_cnt; w0 = words;
    begin_dump(h);
    step(42);
    check_eq("t1_done_cycle", 64'(done_cyc), 64'(h + 41));
    check_eq("t1_last_word_cycle", 64'(last_pop_cyc), 64'(h + 40));
    check_eq("t1_last_word_idx", 64'(last_pop_idx), 64'd37);
    check_eq("t1_done_count", 64'(done_cnt - d0), 64'd1);
    check_eq("t1_words", 64'(words - w0), 64'd38);
    check_eq("t1_idle", 64'(busy_o), 64'd0);
    check_eq("t1_sb_drained", 64'(exp_q.size()), 64'd0);

    // pc == 0 with zero instruction is not a halt
    d0 = done_cnt; w0 = words;
    instr_i = 32'h0; pc_i = 32'h0;
    start_i = 1'b1; step(1); start_i = 1'b0;
    push_expected();
    for (int i = 0; i < 20; i++) begin
      check_eq("t2_busy", 64'(busy_o), 64'd1);
      check_eq("t2_no_strobe", 64'(rf_rd_en_o || ec_rd_en_o), 64'd0);
      check_eq("t2_no_valid", 64'(dump_if.valid), 64'd0);
      step(1);
    end
    pc_i = 32'h40;
    wait_done(d0 + 1, "t2_done");
    check_eq("t2_words", 64'(words - w0), 64'd38);

    // Core contends for the read ports every other cycle
    d0 = done_cnt; w0 = words;
    begin_dump(h);
    for (int i = 0; i < 300 && done_cnt == d0; i++) begin
      core_rd_req_i = ~core_rd_req_i;
      step(1);
    end
    core_rd_req_i = 1'b0;
    check_eq("t3_done", 64'(done_cnt), 64'(d0 + 1));
    check_eq("t3_words", 64'(words - w0), 64'd38);

    // Backpressure right after the first valid
    d0 = done_cnt; w0 = words;
    begin_dump(h);
    for (int i = 0; i < 20 && !dump_if.valid; i++) step(1);
    dump_if.ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("t4_valid_held", 64'(dump_if.valid), 64'd1);
      check_eq("t4_idx_held", 64'(dump_if.idx), 64'd0);
      step(1);
    end
    dump_if.ready = 1'b1;
    wait_done(d0 + 1, "t4_done");
    check_eq("t4_words", 64'(words - w0), 64'd38);

    // Reset in the middle of a dump, then a clean dump
    d0 = done_cnt;
    begin_dump(h);
    for (int i = 0; i < 100 && !(rf_rd_en_o && rf_rd_addr_o == 5'd20); i++) step(1);
    check_eq("t5_reached_idx20", 64'(rf_rd_en_o && rf_rd_addr_o == 5'd20), 64'd1);
    rstb = 1'b1;
    step(1);
    rstb = 1'b0;
    exp_q.delete();
    check_all_zero("t5_after_reset");
    step(5);
    check_eq("t5_no_done", 64'(done_cnt), 64'(d0));
    w0 = words;
    begin_dump(h);
    wait_done(d0 + 1, "t5_redump_done");
    check_eq("t5_words", 64'(words - w0), 64'd38);

    // start during READ is ignored
    d0 = done_cnt; w0 = words;
    begin_dump(h);
    step(5);
    start_i = 1'b1; step(1); start_i = 1'b0;
    wait_done(d0 + 1, "t6_done");
    step(5);
    check_eq("t6_words", 64'(words - w0), 64'd38);
    check_eq("t6_no_restart", 64'(busy_o), 64'd0);
    check_eq("t6_sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
